// File: rtl/moore_dibit_pkg.sv
// Shared definitions for the {x, z} Moore dibit link: state codes, fixed symbols
// and the parity-symbol encoding used by both the transmitter and the receiver.
package moore_dibit_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_GAP    = 3'd4;

    localparam logic [1:0] SYM_IDLE  = 2'b00;
    localparam logic [1:0] SYM_START = 2'b11;

    // Parity symbol is always 01 or 10, so the receiver can reject a frame
    // whose closing symbol looks like idle or start.
    function automatic logic [1:0] parity_sym(input logic p);
        return {p, ~p};
    endfunction

endpackage

// File: rtl/dibit_shifter.sv
// DATA_W-bit parallel-load register that shifts left by one dibit per step and
// exposes its current top dibit.
module dibit_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [1:0]        top_o
);

    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = din_i;
        end else if (shift_i) begin
            shreg_d = shreg_q << 2;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign top_o = shreg_q[DATA_W-1 -: 2];

endmodule

// File: rtl/moore_dibit_tx.sv
// Framed dibit transmitter: START(11), DATA_W/2 data dibits MSB-first, parity
// symbol, GAP idle symbols. All outputs are registered from the next state.
module moore_dibit_tx
    import moore_dibit_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x,
    output logic              z,
    output logic              busy,
    output logic              frame_done
);

    localparam int NDIB  = DATA_W / 2;
    localparam int CNT_W = $clog2(NDIB) + 1;

    localparam logic [CNT_W-1:0] DIB_LAST = CNT_W'(NDIB - 1);
    localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dib_cnt_q, dib_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             par_q, par_d;

    logic [1:0]       sym_q, sym_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic [1:0]       data_top;

    assign accept = din_valid & ready_q & (state_q == ST_IDLE);

    // A dibit leaves the shifter on every edge that enters or stays in DATA,
    // so the register's top always holds the next dibit to emit.
    dibit_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (state_d == ST_DATA),
        .din_i   (din),
        .top_o   (data_top)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dib_cnt_q <= '0;
            gap_cnt_q <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dib_cnt_q <= dib_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            par_q     <= par_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dib_cnt_d = dib_cnt_q;
        gap_cnt_d = gap_cnt_q;
        par_d     = par_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    par_d   = ^din;
                end
            end
            ST_START: begin
                state_d   = ST_DATA;
                dib_cnt_d = '0;
            end
            ST_DATA: begin
                dib_cnt_d = dib_cnt_q + 1'b1;
                if (dib_cnt_q == DIB_LAST) begin
                    state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                gap_cnt_d = '0;
                state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs follow state_d so they change on the same edge as the state they
    // describe; frame_done marks the edge leaving PARITY.
    always_comb begin
        sym_d   = SYM_IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = (state_q == ST_PARITY);
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_START:  sym_d = SYM_START;
            ST_DATA:   sym_d = data_top;
            ST_PARITY: sym_d = parity_sym(par_q);
            default:   sym_d = SYM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_q   <= SYM_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sym_q   <= sym_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x          = sym_q[1];
    assign z          = sym_q[0];
    assign din_ready  = ready_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: doc/moore_dibit_tx.md
# moore_dibit_tx

Moore-style framed dibit transmitter. It accepts a parallel data word over a valid/ready handshake and drives it out as a sequence of 2-bit symbols on {x, z}, one symbol per clock. The frame is start symbol, data dibits MSB-first, parity symbol, then idle gap. It is the sending end for the 4-state {x, z} Moore receiver FSM: every symbol is held for exactly one cycle, and all outputs are functions of state only.

## Interface
- DATA_W, default 8: payload width. Must be even and ≥ 2; the frame carries DATA_W/2 data dibits.
- GAP, default 1: extra idle (00) symbols after parity, range 0..15. The mandatory IDLE cycle is not counted.
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- din, input, DATA_W: payload word; sampled on acceptance.
- din_valid, input, 1: payload available.
- din_ready, output, 1: registered; high only while in IDLE.
- x, output, 1: symbol MSB; registered.
- z, output, 1: symbol LSB; registered.
- busy, output, 1: registered; high from START through the last GAP cycle.
- frame_done, output, 1: registered one-cycle pulse; first cycle after the parity symbol.

## Operation
- States: IDLE, START, DATA, PARITY, GAP.
- Symbol driven in each state:
  - IDLE: 00
  - START: 11
  - DATA: shift_reg[DATA_W-1 : DATA_W-2]
  - PARITY: {p, ~p}, where p = ^payload (XOR reduction)
  - GAP: 00
- PARITY is always 01 or 10, never 00 or 11; the receiver uses this as a frame check.
- IDLE → START: on din_valid & din_ready. din is latched into the shift register and into the parity register.
- START → DATA: unconditional.
- DATA: shift left by 2 each cycle. After DATA_W/2 cycles, go to PARITY. A dibit counter of width $clog2(DATA_W/2)+1 tracks this.
- PARITY → GAP if GAP > 0, else → IDLE.
- GAP: counts GAP cycles, then → IDLE.
- din_valid is ignored outside IDLE. din may change freely after acceptance.
- Data dibits may equal 11 or 00; the receiver frames by count after START, not by symbol value.

## Timing
- Reset values: state IDLE, x=0, z=0, din_ready=0, busy=0, frame_done=0, shift register 0, counters 0.
- din_ready first rises on the first clk edge after rst deasserts.
- Latency: on an accept edge, the next cycle drives START (11). The first data dibit follows one cycle later.
- Frame length: 1 + DATA_W/2 + 1 symbol cycles, then GAP cycles of 00, then IDLE.
- Minimum inter-frame spacing: GAP + 1 cycles of 00. Back-to-back frames are possible: valid held high is accepted in the first IDLE cycle.
- frame_done:
  - Pulses in the cycle immediately after PARITY (first GAP cycle, or the IDLE cycle when GAP=0).
  - Never pulses for an aborted frame.
- busy deasserts in the same cycle din_ready asserts.
- rst mid-frame: outputs drop to 00 immediately (asynchronous). The frame is abandoned with no frame_done. After release the block returns to IDLE with din_ready rising one edge later.
- din_valid asserted during rst is not accepted.

## Structure
- Shared package moore_dibit_pkg holds:
  - state encoding localparams;
  - SYM_IDLE=2'b00 and SYM_START=2'b11;
  - a parity-symbol function.
  - The matching receiver imports the same package.
- One sub-module is natural: dibit_shifter, a DATA_W-bit parallel-load, shift-by-2 register exposing its top dibit.
- The FSM, counters and output registers live in moore_dibit_tx.

## Test plan
- Reset: hold rst for 3 cycles → x,z=00, din_ready=0, busy=0. First edge after release → din_ready=1.
- Single frame, DATA_W=8, GAP=1, din=0xA5 → x,z sequence 11,10,10,01,01,01,00. frame_done pulses on the first 00 after the frame; din_ready=1 one cycle later.
- Parity, din=0x01 → 11,00,00,00,01,10. Parity, din=0xFF → 11,11,11,11,11,01.
- Back-to-back, GAP=0, din_valid held high with 0x3C then 0xC3 → 11,00,11,11,00,01,00,11,11,00,00,11,01. Exactly one 00 separates the frames.
- Stall: din_valid pulsed high while busy → ignored, no extra frame emitted, symbol stream unchanged.
- Abort: assert rst during the second data dibit → x,z=00 the same cycle, no frame_done. The next frame after release is emitted complete and correct.
